// File: rtl/cordic_pkg.sv
// ============================================================================
// Module  : cordic_pkg
// Brief   : Shared FSM encoding and defaults for the CORDIC angle sweeper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_EMIT   = 2'd3
    } sweep_state_t;

    localparam int c_DEFAULT_TIMEOUT = 64;
    localparam int c_ANGLE_W         = 16;

endpackage

`default_nettype wire

// File: rtl/sweep_timer.sv
// ============================================================================
// Module  : sweep_timer
// Brief   : Per-point wait counter; flags the first wait cycle and expiry.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sweep_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_first,
    output logic o_expired
);

    localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    // Count value k means this is the (k+1)-th wait cycle of the point.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign o_first   = (r_count == '0);
    assign o_expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/cordic_sweep.sv
// ============================================================================
// Module  : cordic_sweep
// Brief   : Drives an external CORDIC through an angle sweep, one beat per point.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cordic_sweep
    import cordic_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          start_angle,
    input  logic [15:0]          step,
    input  logic [CNT_W-1:0]     count,
    output logic                 cordic_rst,
    output logic [15:0]          cordic_angle,
    input  logic                 cordic_done,
    input  logic [15:0]          cordic_sin,
    input  logic [15:0]          cordic_cos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_angle,
    output logic [15:0]          out_sin,
    output logic [15:0]          out_cos,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 timeout_err
);

    sweep_state_t     r_state;
    sweep_state_t     w_state_nxt;

    logic [15:0]      r_angle;
    logic [15:0]      r_step;
    logic [CNT_W-1:0] r_remaining;
    logic [15:0]      r_out_angle;
    logic [15:0]      r_out_sin;
    logic [15:0]      r_out_cos;
    logic             r_sweep_done;
    logic             r_timeout_err;

    logic             w_go;
    logic             w_zero_start;
    logic             w_capture;
    logic             w_handshake;
    logic             w_timeout;
    logic             w_last;
    logic             w_tmr_first;
    logic             w_tmr_expired;

    assign w_last = (r_remaining == CNT_W'(1));

    sweep_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ST_LAUNCH),
        .i_enable  (r_state == ST_WAIT),
        .o_first   (w_tmr_first),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_go         = 1'b0;
        w_zero_start = 1'b0;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_go        = 1'b1;
                        w_state_nxt = ST_LAUNCH;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // The CORDIC is still leaving reset in the first wait cycle,
                // so its done level there may be stale from the last point.
                if (!w_tmr_first && cordic_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else if (w_tmr_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_LAUNCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_angle       <= '0;
            r_step        <= '0;
            r_remaining   <= '0;
            r_out_angle   <= '0;
            r_out_sin     <= '0;
            r_out_cos     <= '0;
            r_sweep_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_sweep_done <= w_zero_start | w_timeout | (w_handshake & w_last);
            if (w_go) begin
                r_angle       <= start_angle;
                r_step        <= step;
                r_remaining   <= count;
                r_timeout_err <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_capture) begin
                r_out_angle <= r_angle;
                r_out_sin   <= cordic_sin;
                r_out_cos   <= cordic_cos;
            end
            if (w_handshake) begin
                r_remaining <= r_remaining - CNT_W'(1);
                if (!w_last) begin
                    r_angle <= r_angle + r_step;
                end
            end
        end
    end

    assign cordic_rst   = (r_state == ST_LAUNCH);
    assign cordic_angle = r_angle;
    assign out_valid    = (r_state == ST_EMIT);
    assign out_angle    = r_out_angle;
    assign out_sin      = r_out_sin;
    assign out_cos      = r_out_cos;
    assign busy         = (r_state != ST_IDLE);
    assign sweep_done   = r_sweep_done;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sweep.sv
// ============================================================================
// Module  : tb_cordic_sweep
// Brief   : Directed bench for cordic_sweep with a behavioural CORDIC stand-in.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cordic_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_angle = '0;
    logic [15:0] step = '0;
    logic [7:0]  count = '0;
    logic        cordic_rst;
    logic [15:0] cordic_angle;
    logic        cordic_done;
    logic [15:0] cordic_sin;
    logic [15:0] cordic_cos;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_angle;
    logic [15:0] out_sin;
    logic [15:0] out_cos;
    logic        busy;
    logic        sweep_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_sweep #(
        .CNT_W        (8),
        .TIMEOUT      (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_angle  (start_angle),
        .step         (step),
        .count        (count),
        .cordic_rst   (cordic_rst),
        .cordic_angle (cordic_angle),
        .cordic_done  (cordic_done),
        .cordic_sin   (cordic_sin),
        .cordic_cos   (cordic_cos),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_angle    (out_angle),
        .out_sin      (out_sin),
        .out_cos      (out_cos),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .timeout_err  (timeout_err)
    );

    function automatic logic [15:0] f_sin(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] f_cos(input logic [15:0] a);
        return ~a + 16'd3;
    endfunction

    // CORDIC stand-in: done rises m_delay cycles after its reset pulse.
    // Lazy mode keeps the previous done/result visible for one extra cycle.
    int          m_delay = 20;
    logic        m_never = 1'b0;
    logic        m_lazy  = 1'b0;
    logic [7:0]  m_cnt   = '0;
    logic        m_done_r = 1'b0;
    logic [15:0] m_ang = '0;
    logic [15:0] m_lat = '0;
    logic        m_rst_d = 1'b0;

    always @(posedge clk) begin
        m_rst_d <= cordic_rst;
        if (cordic_rst) begin
            m_cnt    <= '0;
            m_done_r <= m_lazy & m_done_r;
            m_lat    <= cordic_angle;
            if (!m_lazy) m_ang <= cordic_angle;
        end else begin
            if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
            m_done_r <= !m_never && ((int'(m_cnt) + 1) >= m_delay);
            if (m_rst_d) m_ang <= m_lat;
        end
    end

    assign cordic_done = m_done_r;
    assign cordic_sin  = f_sin(m_ang);
    assign cordic_cos  = f_cos(m_ang);

    // Observation of DUT activity, sampled mid-cycle.
    int          cyc = 0;
    int          n_launch = 0, n_beats = 0, n_sd = 0, n_busy = 0, n_unstable = 0;
    int          launch_cyc = 0, hs_cyc = 0, sd_cyc = 0;
    logic [15:0] b_ang [64];
    logic [15:0] b_sin [64];
    logic [15:0] b_cos [64];
    int          lat [64];
    logic        prev_valid = 1'b0, prev_hs = 1'b0;
    logic [15:0] p_ang = '0, p_sin = '0, p_cos = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (cordic_rst) begin
                n_launch   <= n_launch + 1;
                launch_cyc <= cyc;
            end
            if (out_valid && !prev_valid) lat[n_beats % 64] <= cyc - launch_cyc;
            if (out_valid && out_ready) begin
                b_ang[n_beats % 64] <= out_angle;
                b_sin[n_beats % 64] <= out_sin;
                b_cos[n_beats % 64] <= out_cos;
                n_beats <= n_beats + 1;
                hs_cyc  <= cyc;
            end
            if (sweep_done) begin
                n_sd   <= n_sd + 1;
                sd_cyc <= cyc;
            end
            if (busy) n_busy <= n_busy + 1;
            if (prev_valid && !prev_hs &&
                (!out_valid || out_angle !== p_ang || out_sin !== p_sin || out_cos !== p_cos))
                n_unstable <= n_unstable + 1;
        end
        prev_valid <= out_valid && !rst;
        prev_hs    <= out_valid && out_ready;
        p_ang      <= out_angle;
        p_sin      <= out_sin;
        p_cos      <= out_cos;
    end

    task automatic do_start(input logic [15:0] a, input logic [15:0] s, input logic [7:0] c);
        start_angle = a;
        step        = s;
        count       = c;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (cordic_rst !== 1'b0) begin errors++; $display("FAIL reset_cordic_rst got %b exp 0", cordic_rst); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done got %b exp 0", sweep_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        checks++; if (cordic_angle !== 16'h0) begin errors++; $display("FAIL reset_cordic_angle got %h exp 0", cordic_angle); end
        checks++; if ({out_angle, out_sin, out_cos} !== 48'h0) begin
            errors++; $display("FAIL reset_payload got %h %h %h exp 0", out_angle, out_sin, out_cos);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sweep;
        int b0, l0, s0;
        logic [15:0] e;
        b0 = n_beats; l0 = n_launch; s0 = n_sd;
        m_delay = 20; out_ready = 1'b1;
        do_start(16'd0, 16'd30, 8'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        for (int i = 0; i < 400 && n_sd == s0; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (n_sd - s0 != 1) begin errors++; $display("FAIL basic_sweep_done_pulses got %0d exp 1", n_sd - s0); end
        checks++; if (n_beats - b0 != 4) begin errors++; $display("FAIL basic_beats got %0d exp 4", n_beats - b0); end
        checks++; if (n_launch - l0 != 4) begin errors++; $display("FAIL basic_launches got %0d exp 4", n_launch - l0); end
        for (int i = 0; i < 4; i++) begin
            e = 16'(30 * i);
            checks++; if (b_ang[b0 + i] !== e) begin errors++; $display("FAIL basic_angle[%0d] got %h exp %h", i, b_ang[b0 + i], e); end
            checks++; if (b_sin[b0 + i] !== f_sin(e) || b_cos[b0 + i] !== f_cos(e)) begin
                errors++; $display("FAIL basic_sincos[%0d] got %h/%h exp %h/%h", i, b_sin[b0 + i], b_cos[b0 + i], f_sin(e), f_cos(e));
            end
            checks++; if (lat[b0 + i] != 22) begin errors++; $display("FAIL basic_latency[%0d] got %0d exp 22", i, lat[b0 + i]); end
        end
        checks++; if (sd_cyc - hs_cyc != 1) begin errors++; $display("FAIL basic_done_timing got %0d exp 1", sd_cyc - hs_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_count;
        int b0, l0, s0, bz;
        b0 = n_beats; l0 = n_launch; s0 = n_sd; bz = n_busy;
        do_start(16'h1111, 16'd5, 8'd0);
        checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL zero_sweep_done got %b exp 1", sweep_done); end
        @(posedge clk); #1;
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL zero_pulse_width got %b exp 0", sweep_done); end
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (n_launch - l0 != 0) begin errors++; $display("FAIL zero_launches got %0d exp 0", n_launch - l0); end
        checks++; if (n_beats - b0 != 0) begin errors++; $display("FAIL zero_beats got %0d exp 0", n_beats - b0); end
        checks++; if (n_sd - s0 != 1) begin errors++; $display("FAIL zero_done_pulses got %0d exp 1", n_sd - s0); end
        checks++; if (n_busy - bz != 0) begin errors++; $display("FAIL zero_busy_cycles got %0d exp 0", n_busy - bz); end
    endtask

    task automatic test_backpressure;
        int b0, s0, u0, l1;
        b0 = n_beats; s0 = n_sd; u0 = n_unstable;
        m_delay = 5; out_ready = 1'b0;
        do_start(16'h0100, 16'h0040, 8'd2);
        for (int i = 0; i < 50 && !out_valid; i++) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid got %b exp 1", out_valid); end
        l1 = n_launch;
        for (int i = 0; i < 10; i++) begin
            start_angle = 16'h7777; count = 8'd9;
            start = (i == 4);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_held got %b exp 1", out_valid); end
        checks++; if (out_angle !== 16'h0100 || out_sin !== f_sin(16'h0100)) begin
            errors++; $display("FAIL stall_payload got %h/%h exp %h/%h", out_angle, out_sin, 16'h0100, f_sin(16'h0100));
        end
        checks++; if (n_launch != l1 || cordic_rst !== 1'b0) begin errors++; $display("FAIL stall_new_launch got %0d exp 0", n_launch - l1); end
        checks++; if (n_unstable - u0 != 0) begin errors++; $display("FAIL stall_unstable got %0d exp 0", n_unstable - u0); end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && n_sd == s0; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (n_beats - b0 != 2) begin errors++; $display("FAIL stall_beats got %0d exp 2", n_beats - b0); end
        checks++; if (b_ang[b0 + 1] !== 16'h0140) begin errors++; $display("FAIL stall_angle1 got %h exp 0140", b_ang[b0 + 1]); end
        checks++; if (lat[b0] != 7 || lat[b0 + 1] != 7) begin
            errors++; $display("FAIL stall_latency got %0d/%0d exp 7/7", lat[b0], lat[b0 + 1]);
        end
        checks++; if (n_sd - s0 != 1) begin errors++; $display("FAIL stall_done_pulses got %0d exp 1", n_sd - s0); end
    endtask

    task automatic test_wrap;
        int b0, s0;
        b0 = n_beats; s0 = n_sd;
        m_delay = 3; out_ready = 1'b1;
        do_start(16'hFFF0, 16'h0020, 8'd2);
        for (int i = 0; i < 100 && n_sd == s0; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (n_beats - b0 != 2) begin errors++; $display("FAIL wrap_beats got %0d exp 2", n_beats - b0); end
        checks++; if (b_ang[b0] !== 16'hFFF0) begin errors++; $display("FAIL wrap_angle0 got %h exp fff0", b_ang[b0]); end
        checks++; if (b_ang[b0 + 1] !== 16'h0010) begin errors++; $display("FAIL wrap_angle1 got %h exp 0010", b_ang[b0 + 1]); end
        checks++; if (b_sin[b0 + 1] !== f_sin(16'h0010)) begin
            errors++; $display("FAIL wrap_sin1 got %h exp %h", b_sin[b0 + 1], f_sin(16'h0010));
        end
    endtask

    task automatic test_timeout;
        int b0, l0, s0;
        b0 = n_beats; l0 = n_launch; s0 = n_sd;
        m_never = 1'b1; out_ready = 1'b1;
        do_start(16'h1234, 16'd1, 8'd3);
        for (int i = 0; i < 200 && n_sd == s0; i++) begin @(posedge clk); #1; end
        checks++; if (n_sd - s0 != 1) begin errors++; $display("FAIL tmo_done_pulses got %0d exp 1", n_sd - s0); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", timeout_err); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_idle got busy %b valid %b exp 0 0", busy, out_valid);
        end
        checks++; if (sd_cyc - launch_cyc != 65) begin errors++; $display("FAIL tmo_wait_length got %0d exp 65", sd_cyc - launch_cyc); end
        checks++; if (n_beats - b0 != 0 || n_launch - l0 != 1) begin
            errors++; $display("FAIL tmo_activity got beats %0d launches %0d exp 0 1", n_beats - b0, n_launch - l0);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", timeout_err); end
        m_never = 1'b0;
    endtask

    task automatic test_rst_mid_sweep;
        int b0, l0, s0;
        b0 = n_beats; l0 = n_launch; s0 = n_sd;
        m_delay = 20; out_ready = 1'b1;
        do_start(16'd100, 16'd7, 8'd3);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err_cleared got %b exp 0", timeout_err); end
        for (int i = 0; i < 100 && (n_launch - l0) < 2; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (cordic_angle !== 16'd107) begin errors++; $display("FAIL rst_pre_angle got %h exp %h", cordic_angle, 16'd107); end
        rst = 1'b1; start = 1'b1; start_angle = 16'd999; count = 8'd5;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || cordic_rst !== 1'b0 || sweep_done !== 1'b0) begin
            errors++; $display("FAIL rst_ctrl got busy %b valid %b crst %b done %b exp 0", busy, out_valid, cordic_rst, sweep_done);
        end
        checks++; if (cordic_angle !== 16'h0) begin errors++; $display("FAIL rst_cordic_angle got %h exp 0", cordic_angle); end
        checks++; if ({out_angle, out_sin, out_cos} !== 48'h0) begin
            errors++; $display("FAIL rst_payload got %h %h %h exp 0", out_angle, out_sin, out_cos);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        checks++; if (n_sd != s0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", n_sd - s0); end
        checks++; if (n_beats - b0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_aborted got beats %0d busy %b exp 1 0", n_beats - b0, busy);
        end
        b0 = n_beats; s0 = n_sd;
        m_delay = 4;
        do_start(16'd500, 16'd1, 8'd2);
        for (int i = 0; i < 100 && n_sd == s0; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (n_beats - b0 != 2) begin errors++; $display("FAIL rst_restart_beats got %0d exp 2", n_beats - b0); end
        checks++; if (b_ang[b0] !== 16'd500 || b_ang[b0 + 1] !== 16'd501) begin
            errors++; $display("FAIL rst_restart_angles got %h/%h exp %h/%h", b_ang[b0], b_ang[b0 + 1], 16'd500, 16'd501);
        end
        checks++; if (b_cos[b0 + 1] !== f_cos(16'd501)) begin
            errors++; $display("FAIL rst_restart_cos got %h exp %h", b_cos[b0 + 1], f_cos(16'd501));
        end
    endtask

    task automatic test_back_to_back_stale_done;
        int b0, s0;
        logic [15:0] e;
        b0 = n_beats; s0 = n_sd;
        m_lazy = 1'b1; m_delay = 1; out_ready = 1'b1;
        do_start(16'h2000, 16'h1000, 8'd2);
        for (int i = 0; i < 100 && n_sd == s0; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (n_beats - b0 != 2) begin errors++; $display("FAIL stale_beats got %0d exp 2", n_beats - b0); end
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? 16'h2000 : 16'h3000;
            checks++; if (b_ang[b0 + i] !== e || b_sin[b0 + i] !== f_sin(e) || b_cos[b0 + i] !== f_cos(e)) begin
                errors++; $display("FAIL stale_beat[%0d] got %h/%h/%h exp %h/%h/%h", i,
                                   b_ang[b0 + i], b_sin[b0 + i], b_cos[b0 + i], e, f_sin(e), f_cos(e));
            end
            checks++; if (lat[b0 + i] != 3) begin errors++; $display("FAIL stale_latency[%0d] got %0d exp 3", i, lat[b0 + i]); end
        end
        m_lazy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_zero_count();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_rst_mid_sweep();
        test_back_to_back_stale_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
